return_addr_stack: RTL and testbench

//   Hardware LIFO of return addresses for the MCU CALL/RET path.
//   - On CALL it captures the current program count plus one.
//   - On RET it supplies that address, with a one-cycle load strobe, to the program counter's DIN/PC_LD inputs.
//   - It sits between the control unit, which drives PUSH/POP, and the program counter. It is the producer side of the PC load interface.
//

---
 rtl/return_addr_stack.sv | 136 +++++++++++++
 tb/tb_return_addr_stack.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// Return-address LIFO for the CALL/RET path: CALL pushes PC_IN+1, RET hands the
// popped address to the PC with a one-cycle load strobe. Define RAS_WRAP_EN to make
// a push while full overwrite the oldest entry instead of being dropped.
module return_addr_stack #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic [WIDTH-1:0]      PC_IN,
  output logic [WIDTH-1:0]      DOUT,
  output logic                  LD_OUT,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  OVF,
  output logic                  UNF
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);
  localparam logic [WIDTH-1:0]      PC_ONE   = WIDTH'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      dout_q, dout_d;
  logic                  ld_q, ld_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DEPTH_LOG2-1:0] base;

  logic                  empty, full;
  logic                  do_swap, do_pop, do_push, do_ovf;
  logic [DEPTH_LOG2-1:0] top_idx, push_idx, wr_idx;
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Logical slot k lives at physical (base + k); base only moves in the wrap build.
  assign top_idx  = base + count_q[DEPTH_LOG2-1:0] - IDX_ONE;
  assign push_idx = base + count_q[DEPTH_LOG2-1:0];
  assign wr_data  = PC_IN + PC_ONE;

  // PUSH+POP on a non-empty stack is a replace-top; on an empty one the pop is ignored.
  assign do_swap = PUSH &  POP  & ~empty;
  assign do_pop  = POP  & ~PUSH & ~empty;
  assign do_push = PUSH & ~full & ~do_swap;
  assign do_ovf  = PUSH & ~POP  &  full;

`ifdef RAS_WRAP_EN
  logic [DEPTH_LOG2-1:0] base_q, base_d;
  assign base = base_q;
`else
  assign base = '0;
`endif

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    ld_d    = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = push_idx;
`ifdef RAS_WRAP_EN
    base_d  = base_q;
`endif
    if (do_swap) begin
      dout_d = mem_q[top_idx];
      ld_d   = 1'b1;
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end
    if (do_pop) begin
      dout_d  = mem_q[top_idx];
      ld_d    = 1'b1;
      count_d = count_q - CNT_ONE;
    end
    if (do_push) begin
      wr_en   = 1'b1;
      count_d = count_q + CNT_ONE;
    end
    if (POP && empty)
      unf_d = 1'b1;
    if (do_ovf) begin
      ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
      // When full, push_idx already points at the oldest slot.
      wr_en  = 1'b1;
      base_d = base_q + IDX_ONE;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      dout_q  <= '0;
      ld_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef RAS_WRAP_EN
      base_q  <= '0;
`endif
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ld_q    <= ld_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef RAS_WRAP_EN
      base_q  <= base_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_en)
      mem_q[wr_idx] <= wr_data;
  end

  assign DOUT   = dout_q;
  assign LD_OUT = ld_q;
  assign COUNT  = count_q;
  assign EMPTY  = empty;
  assign FULL   = full;
  assign OVF    = ovf_q;
  assign UNF    = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Random + directed bench for return_addr_stack against a queue-based LIFO model.
module tb_return_addr_stack;
  localparam int W     = 10;
  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           PUSH = 1'b0;
  logic           POP = 1'b0;
  logic [W-1:0]   PC_IN = '0;
  logic [W-1:0]   DOUT;
  logic           LD_OUT;
  logic [DL2:0]   COUNT;
  logic           EMPTY, FULL, OVF, UNF;

  int checks = 0;
  int failures = 0;

  int m_q[$];
  int m_dout = 0;
  int m_ld = 0;
  int m_ovf = 0;
  int m_unf = 0;

  always #5 CLK = ~CLK;

  return_addr_stack #(.WIDTH(W), .DEPTH_LOG2(DL2)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .PC_IN(PC_IN),
    .DOUT(DOUT), .LD_OUT(LD_OUT), .COUNT(COUNT), .EMPTY(EMPTY),
    .FULL(FULL), .OVF(OVF), .UNF(UNF)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural LIFO: stack top is the back of the queue.
  task automatic model(input bit rst, input bit p, input bit o, input int pc);
    int v;
    v = (pc + 1) % (1 << W);
    if (rst) begin
      m_q.delete();
      m_dout = 0; m_ld = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    m_ld = 0;
    if (p && o && m_q.size() > 0) begin
      m_dout = m_q[m_q.size()-1];
      m_ld = 1;
      m_q[m_q.size()-1] = v;
    end else begin
      if (o) begin
        if (m_q.size() == 0) m_unf = 1;
        else begin m_dout = m_q.pop_back(); m_ld = 1; end
      end
      if (p) begin
        if (m_q.size() < DEPTH) m_q.push_back(v);
        else begin
          m_ovf = 1;
`ifdef RAS_WRAP_EN
          void'(m_q.pop_front());
          m_q.push_back(v);
`endif
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".dout"},  32'(DOUT),   32'(m_dout));
    chk({ctx, ".ld"},    32'(LD_OUT), 32'(m_ld));
    chk({ctx, ".count"}, 32'(COUNT),  32'(m_q.size()));
    chk({ctx, ".empty"}, 32'(EMPTY),  32'(m_q.size() == 0));
    chk({ctx, ".full"},  32'(FULL),   32'(m_q.size() == DEPTH));
    chk({ctx, ".ovf"},   32'(OVF),    32'(m_ovf));
    chk({ctx, ".unf"},   32'(UNF),    32'(m_unf));
  endtask

  task automatic step(input string ctx, input bit rst, input bit p, input bit o, input int pc);
    RST = rst; PUSH = p; POP = o; PC_IN = W'(pc);
    @(posedge CLK);
    model(rst, p, o, pc);
    #1;
    check_all(ctx);
  endtask

  initial begin
    // 1: reset then idle
    step("rst0", 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0);
    chk("t1_empty", 32'(EMPTY), 1);
    chk("t1_dout",  32'(DOUT),  0);

    // 2: single push/pop, strobe lasts one cycle
    step("t2p", 0, 1, 0, 'h005);
    step("t2o", 0, 0, 1, 0);
    chk("t2_dout", 32'(DOUT), 'h006);
    chk("t2_ld",   32'(LD_OUT), 1);
    step("t2i", 0, 0, 0, 0);
    chk("t2_ld_drop", 32'(LD_OUT), 0);

    // 3: LIFO order
    step("t3p", 0, 1, 0, 'h010);
    step("t3p", 0, 1, 0, 'h020);
    step("t3p", 0, 1, 0, 'h030);
    step("t3o", 0, 0, 1, 0); chk("t3_a", 32'(DOUT), 'h031);
    step("t3o", 0, 0, 1, 0); chk("t3_b", 32'(DOUT), 'h021);
    step("t3o", 0, 0, 1, 0); chk("t3_c", 32'(DOUT), 'h011);

    // 4: PC+1 wraps
    step("t4p", 0, 1, 0, 'h3FF);
    step("t4o", 0, 0, 1, 0);
    chk("t4_dout", 32'(DOUT), 'h000);

    // 5: underflow and PUSH+POP corners
    step("t5u", 0, 0, 1, 0);
    chk("t5_unf", 32'(UNF), 1);
    chk("t5_ld",  32'(LD_OUT), 0);
    step("t5e", 0, 1, 1, 'h040);
    chk("t5_cnt", 32'(COUNT), 1);
    chk("t5_ld2", 32'(LD_OUT), 0);
    step("t5s", 0, 1, 1, 'h050);
    chk("t5_dout", 32'(DOUT), 'h041);
    chk("t5_ld3",  32'(LD_OUT), 1);
    step("t5o", 0, 0, 1, 0);
    chk("t5_top", 32'(DOUT), 'h051);

    // 6: overflow
    step("t6r", 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("t6p", 0, 1, 0, 'h100 + i);
    chk("t6_ovf", 32'(OVF), 1);
    chk("t6_cnt", 32'(COUNT), DEPTH);
    for (int i = 0; i < 8; i++) begin
      step("t6o", 0, 0, 1, 0);
`ifdef RAS_WRAP_EN
      chk("t6_pop", 32'(DOUT), 'h109 - i);
`else
      chk("t6_pop", 32'(DOUT), 'h108 - i);
`endif
    end
    chk("t6_empty", 32'(EMPTY), 1);

    // Reset right after a pop must kill the pending strobe
    step("rp", 0, 1, 0, 'h0AA);
    RST = 0; PUSH = 0; POP = 1;
    @(posedge CLK);
    model(0, 0, 1, 0);
    RST = 1; POP = 0;
    @(posedge CLK);
    model(1, 0, 0, 0);
    #1;
    check_all("rst_after_pop");

    // Random traffic, biased toward full/empty boundaries
    for (int i = 0; i < 600; i++) begin
      int r;
      bit p, o, rs;
      r  = int'($urandom_range(0, 99));
      rs = (r == 0);
      p  = ($urandom_range(0, 99) < ((i / 60) % 2 == 0 ? 70 : 35));
      o  = ($urandom_range(0, 99) < ((i / 60) % 2 == 0 ? 35 : 70));
      step("rnd", rs, p, o, int'($urandom_range(0, (1 << W) - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
